simple_ram: RTL and testbench
=============================

Name: simple_ram

Overview:
Small single-port, flop-based synchronous RAM with one shared address for read and write. It provides a scratch store for datapath blocks that need a few words of local state. An asynchronous clear is supported because the array is built from flops rather than SRAM macros.

Parameters:
DATA_WIDTH, 8, width of each stored word and of data_in/data_out.
ADDR_WIDTH, 3, address width; depth is DEPTH = 2**ADDR_WIDTH (8 words by default).

Ports:
clk  input  1  rising-edge clock; single clock domain.
rst  input  1  asynchronous, active-high reset.
we  input  1  write enable; sampled on rising clk.
addr  input  ADDR_WIDTH  word address shared by the read and write paths.
data_in  input  DATA_WIDTH  write data.
data_out  output  DATA_WIDTH  registered read data.

Behaviour:
- Reset (rst=1, asynchronous, no clock needed):
  - all DEPTH words are cleared to 0;
  - data_out is cleared to 0;
  - these values hold while rst stays high.
- Release of rst is synchronised by the user. The first active edge after release behaves as a normal cycle.
- Write: on a rising clk with we=1, mem[addr] <= data_in. There is no partial or byte write.
- Read: on every rising clk, data_out is registered, so read latency is 1 cycle after addr is presented.
  - we=0: data_out <= mem[addr], using the pre-edge contents.
  - we=1: data_out <= data_in (write-first). Read-during-write to the same address returns the new data.
- data_out holds its value between edges and does not change combinationally with addr.
- Every address in 0..DEPTH-1 is valid. Addresses are full-range, so no out-of-range case exists and no wrap logic is needed.
- Back-to-back writes to the same address: the last write wins. A read on the following cycle returns the last written value.
- Reset asserted mid-write: reset dominates. The in-flight write is discarded and the word reads 0 afterwards.
- There are no handshake or ready signals. The block accepts an operation every cycle.

Decomposition:
- A shared package holds:
  - default DATA_WIDTH/ADDR_WIDTH constants;
  - a derived DEPTH constant;
  - a data-word typedef (logic [DATA_WIDTH-1:0]).
- There is one natural sub-module, ram_word_reg: one DATA_WIDTH-bit register with async clear and load enable. The top level instantiates DEPTH of them via a generate loop, plus a one-hot write decoder and a read mux.

Test Plan:
- Reset check: assert rst with no clock edges. Read all 8 addresses after release -> data_out = 0 for every address, one cycle after each addr.
- Fill and readback:
  - write addr i = 0..7 with data_in = i*8+16 (16, 24, 32, 40, 48, 56, 64, 72), one per cycle, we=1;
  - then read with we=0 -> data_out returns 16..72 in order, each 1 cycle after its addr.
- Write-first: with addr=3 and we=1, data_in=0xA5 -> data_out = 0xA5 after that edge. Then set we=0 and keep addr=3 -> data_out stays 0xA5.
- Overwrite: write addr 5 = 0x11, then write addr 5 = 0x22, then read addr 5 -> 0x22. Addr 4 and addr 6 still hold 48 and 64 from the fill.
- Async reset mid-operation:
  - after the fill, assert rst between clock edges while we=1, addr=2, data_in=0xFF;
  - data_out must go to 0 immediately, without a clock edge;
  - after release, reads of addr 0..7 all return 0.
- we=0 holds contents: drive data_in=0xEE with we=0 across all addresses -> no word changes, and readback matches the prior contents.

Source files
------------

// File: rtl/simple_ram_pkg.sv
// Shared constants and types for the flop-based scratch RAM.
package simple_ram_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 3;
  localparam int DEF_DEPTH      = 2 ** DEF_ADDR_WIDTH;

  typedef logic [DEF_DATA_WIDTH-1:0] data_t;
endpackage

// File: rtl/simple_ram_word_reg.sv
// One storage word: a load-enabled register with asynchronous clear.
module ram_word_reg
  import simple_ram_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= '0;
    else if (load)
      q <= d;
  end

endmodule

// File: rtl/simple_ram.sv
// Single-port flop RAM: shared address, write-first registered read, async clear.
module simple_ram
  import simple_ram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DEPTH-1:0]      wr_sel;
  logic [DATA_WIDTH-1:0] words [DEPTH];
  logic [DATA_WIDTH-1:0] rd_word;

  always_comb begin
    wr_sel = '0;
    if (we)
      wr_sel[addr] = 1'b1;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    ram_word_reg #(
      .WIDTH(DATA_WIDTH)
    ) u_word (
      .clk (clk),
      .rst (rst),
      .load(wr_sel[i]),
      .d   (data_in),
      .q   (words[i])
    );
  end

  assign rd_word = words[addr];

  // Write-first: a write returns the incoming data rather than the old word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      data_out <= '0;
    else if (we)
      data_out <= data_in;
    else
      data_out <= rd_word;
  end

endmodule

// File: tb/tb_simple_ram.sv
// Scoreboard bench for simple_ram: array reference model, queued expectations.
module tb_simple_ram;
  import simple_ram_pkg::*;

  typedef struct {
    data_t      val;
    logic [2:0] a;
    logic       w;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       we = 1'b0;
  logic [2:0] addr = '0;
  data_t      data_in = '0;
  data_t      data_out;

  data_t model [8];
  exp_t  exp_q [$];
  int    total = 0;
  int    bad = 0;

  simple_ram #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .addr    (addr),
    .data_in (data_in),
    .data_out(data_out)
  );

  always #5 clk = ~clk;

  // Monitor: one expectation is consumed per edge that had a tracked operation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (data_out !== e.val) begin
          bad++;
          $display("FAIL rd_data we=%0d addr=%0d got=%h exp=%h", e.w, e.a, data_out, e.val);
        end
      end
    end
  end

  task automatic op(input logic w, input logic [2:0] a, input data_t d);
    exp_t e;
    @(negedge clk);
    we = w;
    addr = a;
    data_in = d;
    e.val = w ? d : model[a];
    e.a = a;
    e.w = w;
    exp_q.push_back(e);
    if (w)
      model[a] = d;
  endtask

  task automatic settle();
    @(negedge clk);
    we = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_now(input string name, input data_t exp_val);
    total++;
    if (data_out !== exp_val) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, data_out, exp_val);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) model[i] = '0;

    // Reset without any clock edge.
    #2 rst = 1'b1;
    #1 check_now("reset_async", 8'h00);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) op(1'b0, 3'(i), 8'h5A);

    // Fill and readback.
    for (int i = 0; i < 8; i++) op(1'b1, 3'(i), 8'(i * 8 + 16));
    for (int i = 0; i < 8; i++) op(1'b0, 3'(i), 8'h00);

    // Write-first, then hold.
    op(1'b1, 3'd3, 8'hA5);
    op(1'b0, 3'd3, 8'h00);

    // Overwrite and neighbours.
    op(1'b1, 3'd5, 8'h11);
    op(1'b1, 3'd5, 8'h22);
    op(1'b0, 3'd5, 8'h00);
    op(1'b0, 3'd4, 8'h00);
    op(1'b0, 3'd6, 8'h00);

    // we=0 with junk data must not disturb contents.
    for (int i = 0; i < 8; i++) op(1'b0, 3'(i), 8'hEE);
    for (int i = 7; i >= 0; i--) op(1'b0, 3'(i), 8'hEE);

    // Randomised mix.
    for (int n = 0; n < 300; n++)
      op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom));

    // Async reset mid-write: leave a nonzero word on data_out first.
    op(1'b1, 3'd1, 8'h3C);
    settle();
    @(negedge clk);
    we = 1'b1;
    addr = 3'd2;
    data_in = 8'hFF;
    #2 rst = 1'b1;
    #1 check_now("reset_mid_write", 8'h00);
    for (int i = 0; i < 8; i++) model[i] = '0;
    @(negedge clk);
    rst = 1'b0;
    we = 1'b0;
    for (int i = 0; i < 8; i++) op(1'b0, 3'(i), 8'h77);
    settle();

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
